// File: rtl/rgb_line_segment_detector.sv
// Streaming RGB-to-luma edge detector. Edge pixels in a row whose direction stays close
// to the run's first pixel are merged into one segment record, 4 cycles after the closing pixel.
module rgb_line_segment_detector #(
  parameter int BIT_WIDTH    = 8,
  parameter int IMAGE_WIDTH  = 960,
  parameter int IMAGE_HEIGHT = 540,
  parameter int FRAME_WIDTH  = 1000,
  parameter int FRAME_HEIGHT = 700,
  parameter int GRAD_THRESH  = 32,
  parameter int ANGLE_TOL    = 8,
  parameter int MIN_LENGTH   = 16
) (
  input  logic                            base_clock,
  input  logic                            n_rst,
  input  logic [BIT_WIDTH-1:0]            in_r,
  input  logic [BIT_WIDTH-1:0]            in_g,
  input  logic [BIT_WIDTH-1:0]            in_b,
  input  logic [$clog2(FRAME_HEIGHT)-1:0] in_vcnt,
  input  logic [$clog2(FRAME_WIDTH)-1:0]  in_hcnt,
  output logic                            out_flag,
  output logic                            out_valid,
  output logic [$clog2(FRAME_HEIGHT)-1:0] out_start_v,
  output logic [$clog2(FRAME_HEIGHT)-1:0] out_end_v,
  output logic [$clog2(FRAME_WIDTH)-1:0]  out_start_h,
  output logic [$clog2(FRAME_WIDTH)-1:0]  out_end_h,
  output logic [7:0]                      out_angle
);
  localparam int VW = $clog2(FRAME_HEIGHT);
  localparam int HW = $clog2(FRAME_WIDTH);
  localparam int AW = $clog2(IMAGE_WIDTH);
  localparam int LW = BIT_WIDTH + 8;
  localparam int DW = BIT_WIDTH + 6;
  localparam logic [VW-1:0]        IMG_H  = VW'(IMAGE_HEIGHT);
  localparam logic [HW-1:0]        IMG_W  = HW'(IMAGE_WIDTH);
  localparam logic [HW-1:0]        H_LAST = HW'(IMAGE_WIDTH - 1);
  localparam logic [BIT_WIDTH+1:0] THR    = (BIT_WIDTH+2)'(GRAD_THRESH);
  localparam logic [7:0]           TOL    = 8'(ANGLE_TOL);
  localparam logic [HW:0]          MINL   = (HW+1)'(MIN_LENGTH);

  typedef struct packed {
    logic                 val;
    logic [VW-1:0]        v;
    logic [HW-1:0]        h;
    logic [BIT_WIDTH-1:0] y;
  } s1_t;
  typedef struct packed {
    logic               val;
    logic               edge_px;
    logic               sx;
    logic               sy;
    logic [BIT_WIDTH:0] ax;
    logic [BIT_WIDTH:0] ay;
    logic [VW-1:0]      v;
    logic [HW-1:0]      h;
  } s2_t;
  typedef struct packed {
    logic          val;
    logic          edge_px;
    logic [7:0]    ang;
    logic [VW-1:0] v;
    logic [HW-1:0] h;
  } s3_t;
  typedef struct packed {
    logic          open;
    logic [7:0]    ang;
    logic [VW-1:0] v;
    logic [HW-1:0] sh;
    logic [HW-1:0] eh;
  } run_t;
  typedef struct packed {
    logic          vld;
    logic [VW-1:0] v;
    logic [HW-1:0] sh;
    logic [HW-1:0] eh;
    logic [7:0]    ang;
  } rec_t;

  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  s3_t  s3_d, s3_q;
  run_t run_d, run_q;
  rec_t rec_d, rec_q, pend_rec_d, pend_rec_q;
  logic flag_d, flag_q, pend_d, pend_q;
  logic [BIT_WIDTH-1:0] prev_y_d, prev_y_q;
  logic seen0_d, seen0_q, rbv_d, rbv_q;

  logic [BIT_WIDTH-1:0] line_buf [IMAGE_WIDTH];
  logic [BIT_WIDTH-1:0] lb_rd;
  logic [LW-1:0]        luma;
  logic signed [BIT_WIDTH:0] gx, gy;
  logic [BIT_WIDTH+1:0] mag;
  logic [DW-1:0]        num, den, quo;
  logic [7:0]           t1, ang, adiff, adist;
  logic                 join_run;
  rec_t                 row_end_rec;

  function automatic rec_t mk_rec(input logic [VW-1:0] v, input logic [HW-1:0] sh,
                                  input logic [HW-1:0] eh, input logic [7:0] a);
    logic [HW:0] len;
    len = {1'b0, eh} - {1'b0, sh} + (HW+1)'(1);
    mk_rec.vld = (len >= MINL);
    mk_rec.v   = v;
    mk_rec.sh  = sh;
    mk_rec.eh  = eh;
    mk_rec.ang = a;
  endfunction

  always_comb begin
    luma     = LW'(in_r) * LW'(77) + LW'(in_g) * LW'(150) + LW'(in_b) * LW'(29);
    s1_d.val = (in_vcnt < IMG_H) && (in_hcnt < IMG_W);
    s1_d.v   = in_vcnt;
    s1_d.h   = in_hcnt;
    s1_d.y   = luma[LW-1:8];

    lb_rd      = line_buf[s1_q.h[AW-1:0]];
    gx         = $signed({1'b0, s1_q.y}) - $signed({1'b0, prev_y_q});
    gy         = $signed({1'b0, s1_q.y}) - $signed({1'b0, lb_rd});
    s2_d.val   = s1_q.val;
    s2_d.sx    = gx[BIT_WIDTH];
    s2_d.sy    = gy[BIT_WIDTH];
    s2_d.ax    = gx[BIT_WIDTH] ? $unsigned(-gx) : $unsigned(gx);
    s2_d.ay    = gy[BIT_WIDTH] ? $unsigned(-gy) : $unsigned(gy);
    s2_d.v     = s1_q.v;
    s2_d.h     = s1_q.h;
    mag        = {1'b0, s2_d.ax} + {1'b0, s2_d.ay};
    s2_d.edge_px = s1_q.val && (s1_q.v != '0) && (s1_q.h != '0) && rbv_q && (mag >= THR);
    prev_y_d   = s1_q.val ? s1_q.y : prev_y_q;
    // Buffer is valid only once a row has been written from h = 0 through the last column.
    seen0_d    = seen0_q | (s1_q.val && (s1_q.h == '0));
    rbv_d      = rbv_q | (s1_q.val && (s1_q.h == H_LAST) && seen0_q);

    if (s2_q.ax >= s2_q.ay) begin
      num = DW'(s2_q.ay) << 5;
      den = DW'(s2_q.ax);
    end else begin
      num = DW'(s2_q.ax) << 5;
      den = DW'(s2_q.ay);
    end
    quo = (den == '0) ? '0 : num / den;
    t1  = (s2_q.ax >= s2_q.ay) ? quo[7:0] : 8'd64 - quo[7:0];
    case ({s2_q.sx, s2_q.sy})
      2'b00:   ang = t1;
      2'b10:   ang = 8'd128 - t1;
      2'b11:   ang = 8'd128 + t1;
      default: ang = 8'd0 - t1;
    endcase
    s3_d.val     = s2_q.val;
    s3_d.edge_px = s2_q.edge_px;
    s3_d.ang     = s2_q.edge_px ? ang : 8'd0;
    s3_d.v       = s2_q.v;
    s3_d.h       = s2_q.h;
  end

  always_comb begin
    run_d       = run_q;
    flag_d      = 1'b0;
    rec_d       = rec_q;
    pend_d      = 1'b0;
    pend_rec_d  = pend_rec_q;
    adiff       = s3_q.ang - run_q.ang;
    adist       = adiff[7] ? 8'd0 - adiff : adiff;
    join_run    = run_q.open && s3_q.edge_px && (s3_q.v == run_q.v) && (adist <= TOL);
    row_end_rec = '0;
    // A held record can only exist right after a row end, when no run is open to collide with it.
    if (pend_q) begin
      flag_d = 1'b1;
      rec_d  = pend_rec_q;
    end
    if (s3_q.val) begin
      if (join_run) begin
        run_d.eh = s3_q.h;
      end else begin
        if (run_q.open) begin
          flag_d = 1'b1;
          rec_d  = mk_rec(run_q.v, run_q.sh, run_q.eh, run_q.ang);
        end
        run_d.open = s3_q.edge_px;
        if (s3_q.edge_px) begin
          run_d.ang = s3_q.ang;
          run_d.v   = s3_q.v;
          run_d.sh  = s3_q.h;
          run_d.eh  = s3_q.h;
        end
      end
      if ((s3_q.h == H_LAST) && run_d.open) begin
        run_d.open  = 1'b0;
        row_end_rec = mk_rec(run_d.v, run_d.sh, run_d.eh, run_d.ang);
        if (flag_d) begin
          pend_d     = 1'b1;
          pend_rec_d = row_end_rec;
        end else begin
          flag_d = 1'b1;
          rec_d  = row_end_rec;
        end
      end
    end
  end

  always_ff @(posedge base_clock) begin
    if (!n_rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      run_q      <= '0;
      rec_q      <= '0;
      flag_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_rec_q <= '0;
      prev_y_q   <= '0;
      seen0_q    <= 1'b0;
      rbv_q      <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      run_q      <= run_d;
      rec_q      <= rec_d;
      flag_q     <= flag_d;
      pend_q     <= pend_d;
      pend_rec_q <= pend_rec_d;
      prev_y_q   <= prev_y_d;
      seen0_q    <= seen0_d;
      rbv_q      <= rbv_d;
    end
  end

  always_ff @(posedge base_clock) begin
    if (n_rst && s1_q.val) line_buf[s1_q.h[AW-1:0]] <= s1_q.y;
  end

  assign out_flag    = flag_q;
  assign out_valid   = rec_q.vld;
  assign out_start_v = rec_q.v;
  assign out_end_v   = rec_q.v;
  assign out_start_h = rec_q.sh;
  assign out_end_h   = rec_q.eh;
  assign out_angle   = rec_q.ang;
endmodule

// File: tb/tb_rgb_line_segment_detector.sv
// Bench for rgb_line_segment_detector on a reduced frame geometry; expected segment
// records come from a pixel-by-pixel reference model of the detector's rules.
module tb_rgb_line_segment_detector;
  localparam int IW = 40, IH = 12, FW = 46, FH = 15;
  localparam int GT = 32, TOL = 8, MINL = 16;
  localparam int VW = $clog2(FH), HW = $clog2(FW);
  localparam int HB = 5;   // first white row of the horizontal-edge pattern
  localparam int VB = 20;  // first white column of the vertical-edge pattern

  logic base_clock = 1'b0;
  logic n_rst = 1'b0;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;
  logic [VW-1:0] in_vcnt = '0;
  logic [HW-1:0] in_hcnt = '0;
  logic out_flag, out_valid;
  logic [VW-1:0] out_start_v, out_end_v;
  logic [HW-1:0] out_start_h, out_end_h;
  logic [7:0] out_angle;

  rgb_line_segment_detector #(
    .BIT_WIDTH(8), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .FRAME_WIDTH(FW),
    .FRAME_HEIGHT(FH), .GRAD_THRESH(GT), .ANGLE_TOL(TOL), .MIN_LENGTH(MINL)
  ) dut (
    .base_clock(base_clock), .n_rst(n_rst), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_vcnt(in_vcnt), .in_hcnt(in_hcnt), .out_flag(out_flag), .out_valid(out_valid),
    .out_start_v(out_start_v), .out_end_v(out_end_v), .out_start_h(out_start_h),
    .out_end_h(out_end_h), .out_angle(out_angle)
  );

  always #5 base_clock = ~base_clock;

  int cyc = 0;
  always @(posedge base_clock) cyc <= cyc + 1;

  typedef struct {
    int due; int vld; int v; int sh; int eh; int ang;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_err = 0, nflags = 0;
  logic [63:0] hold = '0;
  bit   done = 0;

  // reference model state
  int lb[IW];
  int cur[IW];
  bit rbv = 0, seen0 = 0, open = 0;
  int rs = 0, rv = 0, rsh = 0, reh = 0, last_due = 0;
  int slope_v = 0, slope_h = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic logic [63:0] pack_exp(input exp_t e);
    logic [VW-1:0] v;
    logic [HW-1:0] sh, eh;
    logic [7:0] a;
    v = VW'(e.v); sh = HW'(e.sh); eh = HW'(e.eh); a = 8'(e.ang);
    return 64'({e.vld != 0, v, v, sh, eh, a});
  endfunction

  function automatic logic [63:0] pack_dut();
    return 64'({out_valid, out_start_v, out_end_v, out_start_h, out_end_h, out_angle});
  endfunction

  task automatic emit(input int v, input int sh, input int eh, input int a, input int c);
    exp_t e;
    int d;
    d = c + 4;
    if (d <= last_due) d = last_due + 1;  // two closes on one row-end pixel go out back to back
    last_due = d;
    e.due = d; e.v = v; e.sh = sh; e.eh = eh; e.ang = a;
    e.vld = ((eh - sh + 1) >= MINL) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  function automatic int circ_dist(input int a, input int b);
    int d;
    d = (a > b) ? a - b : b - a;
    return (d < 256 - d) ? d : 256 - d;
  endfunction

  task automatic model_pixel(input int v, input int h, input int r, input int g, input int b,
                             input int c);
    int y, gx, gy, ax, ay, t1, a;
    bit edge_px;
    if (v >= IH || h >= IW) return;
    y = (77 * r + 150 * g + 29 * b) / 256;
    edge_px = 0;
    a = 0;
    if (v >= 1 && h >= 1 && rbv) begin
      gx = y - cur[h-1];
      gy = y - lb[h];
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      if (ax + ay >= GT) begin
        edge_px = 1;
        t1 = (ax >= ay) ? (32 * ay) / ax : 64 - (32 * ax) / ay;
        if (gx >= 0 && gy >= 0)     a = t1;
        else if (gx < 0 && gy >= 0) a = 128 - t1;
        else if (gx < 0)            a = 128 + t1;
        else                        a = (256 - t1) % 256;
      end
    end
    cur[h] = y;
    lb[h] = y;
    if (h == 0) seen0 = 1;
    if (h == IW - 1 && seen0) rbv = 1;
    if (open && edge_px && v == rv && circ_dist(a, rs) <= TOL) begin
      reh = h;
    end else begin
      if (open) emit(rv, rsh, reh, rs, c);
      open = edge_px;
      if (edge_px) begin rs = a; rv = v; rsh = h; reh = h; end
    end
    if (h == IW - 1 && open) begin
      emit(rv, rsh, reh, rs, c);
      open = 0;
    end
  endtask

  function automatic int clamp8(input int x);
    return (x < 0) ? 0 : (x > 255) ? 255 : x;
  endfunction

  task automatic get_px(input int mode, input int v, input int h,
                        output int r, output int g, output int b);
    int base;
    case (mode)
      0: base = 100;
      1: base = (v >= HB) ? 255 : 0;
      2: base = (v >= HB && h <= 10) ? 255 : 0;
      3: base = (h >= VB) ? 255 : 0;
      4: base = 128 + slope_v * (v - IH / 2) + slope_h * (h - IW / 2);
      default: base = 0;
    endcase
    if (mode == 5) begin
      r = int'($urandom_range(0, 255)); g = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
    end else if (mode == 4) begin
      r = clamp8(base + int'($urandom_range(0, 3)));
      g = clamp8(base + int'($urandom_range(0, 3)));
      b = clamp8(base + int'($urandom_range(0, 3)));
    end else begin
      r = base; g = base; b = base;
    end
  endtask

  // rst_v/rst_h < 0: no reset; otherwise n_rst is pulled low for the cycle of that pixel
  task automatic run_frame(input int mode, input int rst_v, input int rst_h);
    int r, g, b, f0, expn;
    f0 = nflags;
    for (int v = 0; v < FH; v++) begin
      for (int h = 0; h < FW; h++) begin
        get_px(mode, v, h, r, g, b);
        in_r = 8'(r); in_g = 8'(g); in_b = 8'(b);
        in_vcnt = VW'(v); in_hcnt = HW'(h);
        if (v == rst_v && h == rst_h) begin
          n_rst = 1'b0;
          rbv = 0; seen0 = 0; open = 0;
        end else begin
          n_rst = 1'b1;
          model_pixel(v, h, r, g, b, cyc);
        end
        @(posedge base_clock); #1;
      end
    end
    n_rst = 1'b1;
    if (mode < 4) begin
      case (mode)
        0: expn = 0;
        1: expn = 1;
        2: expn = (IH - HB) + 1;
        default: expn = IH - 1;
      endcase
      if (rst_v >= 0) expn = 0;
      chk("frame_record_count", 64'(nflags - f0), 64'(expn));
    end
  endtask

  task automatic check_cycle();
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      hold = pack_exp(e);
      chk("out_flag_pulse", 64'(out_flag), 64'd1);
      chk("record_fields", pack_dut(), hold);
    end else begin
      chk("out_flag_idle", 64'(out_flag), 64'd0);
      chk("held_fields", pack_dut(), hold);
    end
    if (out_flag) nflags++;
    if (!n_rst) begin
      hold = '0;
      while (exp_q.size() > 0 && exp_q[$].due > cyc) void'(exp_q.pop_back());
    end
  endtask

  initial begin
    n_rst = 1'b0;
    in_vcnt = VW'(IH);
    in_hcnt = '0;
    repeat (2) @(posedge base_clock);
    #1;
    chk("reset_outputs", 64'({out_flag, out_valid, out_start_v, out_end_v, out_start_h,
                              out_end_h, out_angle}), 64'd0);
    n_rst = 1'b1;
    fork
      begin
        run_frame(0, -1, -1);
        run_frame(0, -1, -1);
        run_frame(1, -1, -1);
        run_frame(1, -1, -1);
        run_frame(2, -1, -1);
        run_frame(3, -1, -1);
        run_frame(1, HB, 20);
        run_frame(1, -1, -1);
        for (int f = 0; f < 8; f++) begin
          slope_v = int'($urandom_range(0, 80)) - 40;
          slope_h = int'($urandom_range(0, 80)) - 40;
          run_frame(4, -1, -1);
        end
        run_frame(5, -1, -1);
        run_frame(5, -1, -1);
        slope_v = int'($urandom_range(0, 80)) - 40;
        slope_h = int'($urandom_range(0, 80)) - 40;
        run_frame(4, int'($urandom_range(1, IH - 1)), int'($urandom_range(1, IW - 1)));
        run_frame(5, -1, -1);
        in_vcnt = VW'(IH);
        repeat (10) @(posedge base_clock);
        #1;
        chk("pending_records_drained", 64'(exp_q.size()), 64'd0);
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge base_clock);
          if (!done) check_cycle();
        end
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
